// File: rtl/sprite_blitter_if.sv
// Sprite blitter bus: draw request, sprite ROM read port and screen buffer write port.
// master = blitter side, slave = host/memory side.
interface sprite_blitter_if;
    logic        start;
    logic [7:0]  spriteX;
    logic [6:0]  spriteY;
    logic [10:0] spriteAddr;
    logic [2:0]  spriteData;
    logic [14:0] screenAddr;
    logic [2:0]  screenData;
    logic        screenWrite;
    logic        busy;
    logic        done;

    modport master (
        input  start, spriteX, spriteY, spriteData,
        output spriteAddr, screenAddr, screenData, screenWrite, busy, done
    );

    modport slave (
        output start, spriteX, spriteY, spriteData,
        input  spriteAddr, screenAddr, screenData, screenWrite, busy, done
    );
endinterface

// File: rtl/sprite_blitter.sv
// Copies an SPR_W x SPR_H sprite from ROM to the screen buffer with clipping; one pixel per cycle, write 1 cycle after ROM address.
// No backpressure: start is only honoured in IDLE. Define SPRITE_TRANSPARENCY_EN to skip pixels matching TRANSPARENT_COLOR.
module sprite_blitter #(
    parameter int         SPR_W             = 40,
    parameter int         SPR_H             = 40,
    parameter int         SCR_W             = 160,
    parameter int         SCR_H             = 120,
    parameter logic [2:0] TRANSPARENT_COLOR = 3'b000
) (
    input logic              clk,
    input logic              spriteBlitterReset,
    sprite_blitter_if.master bus
);
    localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

`ifdef SPRITE_TRANSPARENCY_EN
    localparam bit TRANSP_EN = 1'b1;
`else
    localparam bit TRANSP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [7:0]    x_q;
    logic [6:0]    y_q;
    logic [10:0]   addr_q;
    logic [14:0]   saddr_q;
    logic          pix_vld;
    logic          pix_inb;
    logic          last_pix;
    logic          key_hit;
    logic [31:0]   px;
    logic [31:0]   py;

    assign last_pix = (col == CW'(SPR_W - 1)) && (row == RW'(SPR_H - 1));

    // 32-bit screen coordinates so the clip test sees the true position past the screen edge
    always_comb begin
        px = 32'(x_q) + 32'(col);
        py = 32'(y_q) + 32'(row);
    end

    always_ff @(posedge clk or posedge spriteBlitterReset) begin
        if (spriteBlitterReset) state <= IDLE;
        else                    state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last_pix)  state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge spriteBlitterReset) begin
        if (spriteBlitterReset) begin
            col     <= '0;
            row     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            saddr_q <= '0;
            pix_vld <= 1'b0;
            pix_inb <= 1'b0;
        end else begin
            // pixel position travels one stage behind the ROM address to meet the ROM data
            pix_vld <= (state == RUN);
            pix_inb <= (px < 32'(SCR_W)) && (py < 32'(SCR_H));
            saddr_q <= 15'(py * 32'(SCR_W) + px);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        x_q    <= bus.spriteX;
                        y_q    <= bus.spriteY;
                        col    <= '0;
                        row    <= '0;
                        addr_q <= '0;
                    end
                end
                RUN: begin
                    if (last_pix) begin
                        col    <= '0;
                        row    <= '0;
                        addr_q <= '0;
                    end else begin
                        addr_q <= addr_q + 11'd1;
                        if (col == CW'(SPR_W - 1)) begin
                            col <= '0;
                            row <= row + RW'(1);
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign key_hit         = TRANSP_EN && (bus.spriteData == TRANSPARENT_COLOR);
    assign bus.spriteAddr  = addr_q;
    assign bus.screenAddr  = saddr_q;
    assign bus.screenData  = pix_vld ? bus.spriteData : 3'b000;
    assign bus.screenWrite = pix_vld && pix_inb && !key_hit;
    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: cycle-indexed reference model plus directed and random blits.
module tb_sprite_blitter;
    localparam int SPR_W = 40;
    localparam int SPR_H = 40;
    localparam int SCR_W = 160;
    localparam int SCR_H = 120;
    localparam int NPIX  = SPR_W * SPR_H;
    localparam logic [2:0] TKEY = 3'b000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    sprite_blitter_if bif ();

    sprite_blitter #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .SCR_W(SCR_W), .SCR_H(SCR_H), .TRANSPARENT_COLOR(TKEY)
    ) dut (
        .clk(clk),
        .spriteBlitterReset(rst),
        .bus(bif)
    );

    always #5 clk = ~clk;

    logic [2:0] rom [NPIX];
    logic [2:0] rom_q = 3'b000;
    always @(posedge clk) begin
        if (int'(bif.spriteAddr) < NPIX) rom_q <= rom[bif.spriteAddr];
        else                             rom_q <= 3'b000;
    end
    assign bif.spriteData = rom_q;

    int checks = 0;
    int errors = 0;

    // model state: blit accepted at edge se; k = cycle number inside the blit (1 = first address)
    int cyc = 0, se = 0, mx = 0, my = 0;
    bit active = 1'b0;
    int wr_cnt, first_addr, first_data, last_addr, last_data, done_cnt, done_k;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    function automatic bit pix_write(input int i, input int x, input int y);
        bit on;
        on = (x + i % SPR_W < SCR_W) && (y + i / SPR_W < SCR_H);
`ifdef SPRITE_TRANSPARENCY_EN
        on = on && (rom[i] != TKEY);
`endif
        return on;
    endfunction

    function automatic int exp_addr(input int i, input int x, input int y);
        return (y + i / SPR_W) * SCR_W + x + i % SPR_W;
    endfunction

    always @(posedge rst) active = 1'b0;

    always @(posedge clk) begin
        int kb;
        if (!rst) begin
            kb = cyc - se + 1;
            if ((!active || kb >= NPIX + 3) && bif.start) begin
                active = 1'b1;
                se = cyc + 1;
                mx = int'(bif.spriteX);
                my = int'(bif.spriteY);
                wr_cnt = 0; first_addr = -1; first_data = -1;
                last_addr = -1; last_data = -1; done_cnt = 0; done_k = 0;
            end
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        int k;
        bit ew;
        if (rst) begin
            chk("rst_busy", int'(bif.busy), 0);
            chk("rst_done", int'(bif.done), 0);
            chk("rst_write", int'(bif.screenWrite), 0);
            chk("rst_spriteAddr", int'(bif.spriteAddr), 0);
        end else begin
            k = active ? cyc - se + 1 : 0;
            if (k >= NPIX + 3) k = 0;
            chk("busy", int'(bif.busy), int'(k >= 1));
            chk("done", int'(bif.done), int'(k == NPIX + 2));
            ew = (k >= 2 && k <= NPIX + 1) ? pix_write(k - 2, mx, my) : 1'b0;
            chk("screenWrite", int'(bif.screenWrite), int'(ew));
            if (k >= 1 && k <= NPIX) chk("spriteAddr", int'(bif.spriteAddr), k - 1);
            if (ew) begin
                chk("screenAddr", int'(bif.screenAddr), exp_addr(k - 2, mx, my));
                chk("screenData", int'(bif.screenData), int'(rom[k - 2]));
            end
            if (bif.screenWrite) begin
                wr_cnt++;
                if (wr_cnt == 1) begin
                    first_addr = int'(bif.screenAddr);
                    first_data = int'(bif.screenData);
                end
                last_addr = int'(bif.screenAddr);
                last_data = int'(bif.screenData);
            end
            if (bif.done) begin
                done_cnt++;
                done_k = k;
            end
        end
    end

    task automatic blit_start(input int x, input int y);
        int n = 0;
        @(negedge clk);
        while (bif.busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) timeout_fail("idle_wait");
        bif.spriteX = 8'(x);
        bif.spriteY = 7'(y);
        bif.start   = 1'b1;
        @(negedge clk);
        bif.start   = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt == 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) timeout_fail("done_wait");
        @(negedge clk);
    endtask

    task automatic check_blit(input string name, input int ewr, input int efa, input int efd,
                              input int ela, input int eld);
        chk({name, "_writes"}, wr_cnt, ewr);
        chk({name, "_first_addr"}, first_addr, efa);
        chk({name, "_first_data"}, first_data, efd);
        chk({name, "_last_addr"}, last_addr, ela);
        chk({name, "_last_data"}, last_data, eld);
        chk({name, "_done_cycle"}, done_k, NPIX + 2);
        chk({name, "_done_count"}, done_cnt, 1);
    endtask

    initial begin
        bif.start   = 1'b0;
        bif.spriteX = '0;
        bif.spriteY = '0;
        for (int i = 0; i < NPIX; i++) rom[i] = 3'(i % 8);
        #1;
        chk("init_busy", int'(bif.busy), 0);
        chk("init_screenWrite", int'(bif.screenWrite), 0);
        chk("init_screenAddr", int'(bif.screenAddr), 0);
        chk("init_screenData", int'(bif.screenData), 0);
        #11 rst = 1'b0;

        // full on-screen sprite at the origin
        blit_start(0, 0);
        wait_done();
`ifdef SPRITE_TRANSPARENCY_EN
        check_blit("origin", 1400, 1, 1, 6279, 7);
`else
        check_blit("origin", 1600, 0, 0, 6279, 7);
`endif

        // bottom-right corner: only a 10x10 block survives clipping
        for (int i = 0; i < NPIX; i++) rom[i] = 3'(i % 7 + 1);
        blit_start(150, 110);
        wait_done();
        check_blit("clip", 100, 17750, 1, 19199, 6);

        // second start mid-blit must be ignored
        blit_start(30, 40);
        repeat (498) @(negedge clk);
        bif.spriteX = 8'd20;
        bif.spriteY = 7'd20;
        bif.start   = 1'b1;
        @(negedge clk);
        bif.start   = 1'b0;
        wait_done();
        check_blit("restart", 1600, 6430, 1, 12709, 4);

        // asynchronous reset in the middle of a blit
        blit_start(60, 5);
        repeat (799) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", int'(bif.busy), 0);
        chk("abort_write", int'(bif.screenWrite), 0);
        chk("abort_spriteAddr", int'(bif.spriteAddr), 0);
        chk("abort_screenAddr", int'(bif.screenAddr), 0);
        chk("abort_screenData", int'(bif.screenData), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (1000) @(negedge clk);
        chk("abort_no_done", done_cnt, 0);
        blit_start(10, 10);
        wait_done();
        check_blit("after_reset", 1600, 1610, 1, 7889, 4);

        // single non-key pixel
        for (int i = 0; i < NPIX; i++) rom[i] = 3'b000;
        rom[0] = 3'd5;
        blit_start(0, 0);
        wait_done();
`ifdef SPRITE_TRANSPARENCY_EN
        check_blit("transp", 1, 0, 5, 0, 5);
`else
        check_blit("transp", 1600, 0, 5, 6279, 0);
`endif

        // random positions and contents, checked cycle by cycle by the model
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < NPIX; i++) rom[i] = 3'($urandom_range(0, 7));
            blit_start(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)));
            wait_done();
            chk("rand_done_cycle", done_k, NPIX + 2);
            chk("rand_done_count", done_cnt, 1);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sprite_blitter.md
SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 SHALL have parameter SPR_W, default 40, sprite width in pixels.
REQ-002 SHALL have parameter SPR_H, default 40, sprite height in pixels.
REQ-003 SHALL have parameter SCR_W, default 160, screen width in pixels.
REQ-004 SHALL have parameter SCR_H, default 120, screen height in pixels.
REQ-005 SHALL have parameter TRANSPARENT_COLOR, default 3'b000, key colour used only when REQ-034 applies.
REQ-006 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port spriteBlitterReset, input, 1, reset; asynchronous, active-high.
REQ-008 SHALL have port start, input, 1, request to draw one sprite.
REQ-009 SHALL have port spriteX, input, 8, screen column of the sprite's top-left pixel.
REQ-010 SHALL have port spriteY, input, 7, screen row of the sprite's top-left pixel.
REQ-011 SHALL have port spriteAddr, output, 11, sprite ROM read address.
REQ-012 SHALL have port spriteData, input, 3, sprite ROM colour, valid one cycle after spriteAddr.
REQ-013 SHALL have port screenAddr, output, 15, screen buffer write address = row*SCR_W + column.
REQ-014 SHALL have port screenData, output, 3, colour written to the screen buffer.
REQ-015 SHALL have port screenWrite, output, 1, screen buffer write enable.
REQ-016 SHALL have port busy, output, 1, high while a blit is in progress.
REQ-017 SHALL have port done, output, 1, one-cycle pulse marking blit completion.

Function
REQ-018 SHALL implement states IDLE, RUN, DRAIN and DONE.
REQ-019 In IDLE with start=1, SHALL latch spriteX/spriteY, clear row/column counters and enter RUN on the next edge.
REQ-020 SHALL ignore start in every state other than IDLE; latched coordinates stay fixed for the whole blit.
REQ-021 In RUN, SHALL present spriteAddr = row*SPR_W + col, starting at 0 and incrementing by 1 per cycle.
REQ-022 Column SHALL wrap from SPR_W-1 to 0 and increment row; after address SPR_W*SPR_H-1 (1599) the FSM SHALL enter DRAIN.
REQ-023 SHALL register pixel coordinates alongside spriteAddr so that screenAddr, screenData (=spriteData) and screenWrite are valid exactly one cycle after the corresponding spriteAddr.
REQ-024 screenAddr SHALL be (latchedY+row)*SCR_W + (latchedX+col), computed at widths that do not overflow before the clip check.
REQ-025 SHALL deassert screenWrite for any pixel with latchedX+col >= SCR_W or latchedY+row >= SCR_H (clipping); addresses still advance.
REQ-026 DRAIN SHALL last one cycle and carry the final write; the FSM SHALL then enter DONE.
REQ-027 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-028 busy SHALL be 1 in RUN, DRAIN and DONE, and 0 in IDLE.
REQ-029 With start sampled at edge 0, SHALL issue addresses in cycles 1-1600, writes in cycles 2-1601, done in cycle 1602.
REQ-030 start asserted in the DONE cycle SHALL be ignored; a new blit may begin from the following IDLE cycle.

Reset
REQ-031 spriteBlitterReset=1 SHALL immediately force state IDLE and spriteAddr=0, screenAddr=0, screenData=0, screenWrite=0, busy=0, done=0, counters=0, regardless of clk.
REQ-032 Reset during a blit SHALL abort it with no further writes and no done pulse.
REQ-033 After reset deasserts, the first start SHALL be accepted on the next rising edge.

Configuration
REQ-034 With SPRITE_TRANSPARENCY_EN defined, SHALL suppress screenWrite for any pixel whose spriteData equals TRANSPARENT_COLOR; timing and done unaffected.
REQ-035 Without SPRITE_TRANSPARENCY_EN, SHALL write every unclipped pixel regardless of colour; TRANSPARENT_COLOR unused.

Verification
REQ-036 Start at (0,0), ROM[i]=i mod 8 -> 1600 writes; first screenAddr 0 data 0; last screenAddr 6279 data 7; done in cycle 1602.
REQ-037 Start at (150,110) -> exactly 100 writes, first screenAddr 17750, last 19199; no write with column >=160 or row >=120.
REQ-038 Start pulsed again at cycle 500 with new (20,20) -> ignored; all writes use the original coordinates; one done pulse.
REQ-039 Reset asserted at cycle 800 between edges -> outputs zero immediately, no done; new start at (10,10) then completes normally.
REQ-040 SPRITE_TRANSPARENCY_EN defined, all-zero ROM except ROM[0]=5 -> exactly 1 write (screenAddr 0, data 5); done still in cycle 1602.
